// File: rtl/i2c_target_byte.sv
// Single-address I2C target: decodes START/STOP, ACKs TARGET_ADDR, receives write bytes, returns tx_data on reads.
// Optional macro I2C_TARGET_SYNC_EN adds 2-flop synchronizers on SCL/SDA for asynchronous masters.
module i2c_target_byte #(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic       clk_400,
    input  logic       rst_n,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       addr_hit,
    output logic       busy,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ACK_ADDR = 4'd2,
        RX       = 4'd3,
        ACK_RX   = 4'd4,
        TX       = 4'd5,
        MACK     = 4'd6,
        IGNORE   = 4'd7
    } state_t;

    logic scl_s, sda_s;

`ifdef I2C_TARGET_SYNC_EN
    logic [1:0] scl_sync_q, sda_sync_q;

    always_ff @(posedge clk_400) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], SCL};
            sda_sync_q <= {sda_sync_q[0], SDA};
        end
    end

    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`else
    assign scl_s = SCL;
    assign sda_s = SDA;
`endif

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        rw_q, rw_d;
    logic        phase_q, phase_d;
    logic        sda_low_q, sda_low_d;
    logic        scl_q, sda_q;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_req_q, tx_req_d;
    logic        addr_hit_q, addr_hit_d;
    logic        busy_q, busy_d;

    logic       rise, fall, start, stop;
    logic [7:0] shift_in;

    assign rise     = scl_s & ~scl_q;
    assign fall     = ~scl_s & scl_q;
    assign start    = scl_s & scl_q & sda_q & ~sda_s;
    assign stop     = scl_s & scl_q & ~sda_q & sda_s;
    assign shift_in = {shift_q[6:0], sda_s};

    // Open-drain: only ever pull low or release.
    assign SDA = sda_low_q ? 1'b0 : 1'bz;

    always_ff @(posedge clk_400) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd7;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
            sda_low_q  <= 1'b0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            addr_hit_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            sda_low_q  <= sda_low_d;
            scl_q      <= scl_s;
            sda_q      <= sda_s;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            addr_hit_q <= addr_hit_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        sda_low_d  = sda_low_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        addr_hit_d = addr_hit_q;
        busy_d     = busy_q;

        if (stop) begin
            state_d    = IDLE;
            cnt_d      = 3'd7;
            sda_low_d  = 1'b0;
            busy_d     = 1'b0;
            addr_hit_d = 1'b0;
        end else if (start) begin
            state_d    = ADDR;
            cnt_d      = 3'd7;
            sda_low_d  = 1'b0;
            busy_d     = 1'b1;
            addr_hit_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (rise) begin
                    shift_d = shift_in;
                    if (cnt_q == 3'd0) begin
                        if (shift_in[7:1] == TARGET_ADDR) begin
                            state_d = ACK_ADDR;
                            rw_d    = shift_in[0];
                            phase_d = 1'b0;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                // phase_q marks that the ACK clock has already risen.
                ACK_ADDR, ACK_RX: begin
                    if (fall && !phase_q) begin
                        sda_low_d  = 1'b1;
                        addr_hit_d = 1'b1;
                    end else if (rise) begin
                        phase_d = 1'b1;
                        if (state_q == ACK_ADDR && rw_q) begin
                            shift_d  = tx_data;
                            tx_req_d = 1'b1;
                        end
                    end else if (fall) begin
                        cnt_d = 3'd7;
                        if (state_q == ACK_ADDR && rw_q) begin
                            state_d   = TX;
                            sda_low_d = ~shift_q[7];
                            phase_d   = 1'b0;
                        end else begin
                            state_d   = RX;
                            sda_low_d = 1'b0;
                        end
                    end
                end
                RX: if (rise) begin
                    shift_d = shift_in;
                    if (cnt_q == 3'd0) begin
                        rx_data_d  = shift_in;
                        rx_valid_d = 1'b1;
                        state_d    = ACK_RX;
                        phase_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                // In TX, phase_q means bit7 of a freshly loaded byte is still to be presented.
                TX: if (fall) begin
                    if (phase_q) begin
                        sda_low_d = ~shift_q[7];
                        phase_d   = 1'b0;
                    end else if (cnt_q == 3'd0) begin
                        sda_low_d = 1'b0;
                        state_d   = MACK;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        sda_low_d = ~shift_q[6];
                        cnt_d     = cnt_q - 3'd1;
                    end
                end
                MACK: if (rise) begin
                    if (!sda_s) begin
                        shift_d  = tx_data;
                        tx_req_d = 1'b1;
                        state_d  = TX;
                        cnt_d    = 3'd7;
                        phase_d  = 1'b1;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                default: sda_low_d = 1'b0;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign addr_hit  = addr_hit_q;
    assign busy      = busy_q;
    assign state_out = state_q;

endmodule
